// File: rtl/samp_push_arbiter_if.sv
// Push-side bundle between two sample producers, the arbiter and the I/Q FIFO.
// The arbiter takes the slave view; the producer/FIFO environment takes the master view.
interface samp_push_arbiter_if #(
  parameter int SAMP_W = 24
);
  logic              ReqA_Valid;
  logic [SAMP_W-1:0] ReqA_I;
  logic [SAMP_W-1:0] ReqA_Q;
  logic              ReqA_Ready;
  logic              ReqB_Valid;
  logic [SAMP_W-1:0] ReqB_I;
  logic [SAMP_W-1:0] ReqB_Q;
  logic              ReqB_Ready;
  logic              fifo_full;
  logic              PushIn;
  logic [SAMP_W-1:0] SampI;
  logic [SAMP_W-1:0] SampQ;
  logic              GrantSrc;

  modport master (
    output ReqA_Valid, ReqA_I, ReqA_Q,
    output ReqB_Valid, ReqB_I, ReqB_Q,
    output fifo_full,
    input  ReqA_Ready, ReqB_Ready,
    input  PushIn, SampI, SampQ, GrantSrc
  );

  modport slave (
    input  ReqA_Valid, ReqA_I, ReqA_Q,
    input  ReqB_Valid, ReqB_I, ReqB_Q,
    input  fifo_full,
    output ReqA_Ready, ReqB_Ready,
    output PushIn, SampI, SampQ, GrantSrc
  );
endinterface

// File: rtl/samp_push_arbiter.sv
// Two-source sticky round-robin arbiter in front of the I/Q FIFO push port, with a
// burst limit that forces a hand-over only when the other source is waiting.
module samp_push_arbiter #(
  parameter int SAMP_W    = 24,
  parameter int BURST_MAX = 4
) (
  input  logic                 Clk,
  input  logic                 Reset,
  samp_push_arbiter_if.slave   bus,
  output logic [15:0]          StallCnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  // Saturating burst update; a change of owner restarts the burst at one.
  function automatic logic [3:0] burst_next(input logic [3:0] cnt, input logic same_src);
    logic [3:0] res;
    if (!same_src) begin
      res = 4'd1;
    end else if (cnt >= BURST_LIM) begin
      res = BURST_LIM;
    end else begin
      res = cnt + 4'd1;
    end
    return res;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    logic [15:0] res;
    if (val == 16'hFFFF) begin
      res = val;
    end else begin
      res = val + 16'd1;
    end
    return res;
  endfunction

  logic [1:0]  own_r;
  logic [1:0]  own_nxt_s;
  logic [3:0]  bcnt_r;
  logic [3:0]  bcnt_nxt_s;
  logic [15:0] stall_cnt_r;
  logic        gnt_a_s;
  logic        gnt_b_s;
  logic        xfer_s;
  logic        same_src_s;
  logic        stall_ev_s;

  // Grant selection from current ownership, burst count and the two valids.
  always_comb begin
    gnt_a_s = 1'b0;
    gnt_b_s = 1'b0;
    case (own_r)
      OWN_A: begin
        if (bus.ReqA_Valid && ((bcnt_r < BURST_LIM) || !bus.ReqB_Valid)) begin
          gnt_a_s = 1'b1;
        end else if (bus.ReqB_Valid) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      end
      OWN_B: begin
        if (bus.ReqB_Valid && ((bcnt_r < BURST_LIM) || !bus.ReqA_Valid)) begin
          gnt_b_s = 1'b1;
        end else if (bus.ReqA_Valid) begin
          gnt_a_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      end
      default: begin
        if (bus.ReqA_Valid) begin
          gnt_a_s = 1'b1;
        end else if (bus.ReqB_Valid) begin
          gnt_b_s = 1'b1;
        end else begin
          gnt_a_s = 1'b0;
          gnt_b_s = 1'b0;
        end
      end
    endcase
  end

  assign xfer_s     = (gnt_a_s | gnt_b_s) & ~bus.fifo_full;
  assign same_src_s = (gnt_a_s && (own_r == OWN_A)) || (gnt_b_s && (own_r == OWN_B));
  assign stall_ev_s = (bus.ReqA_Valid | bus.ReqB_Valid) & bus.fifo_full;

  assign bus.ReqA_Ready = gnt_a_s & ~bus.fifo_full;
  assign bus.ReqB_Ready = gnt_b_s & ~bus.fifo_full;
  assign bus.PushIn     = xfer_s;
  assign bus.GrantSrc   = gnt_b_s & ~bus.fifo_full;
  assign StallCnt       = stall_cnt_r;

  // Write-data mux: shows the granted source even while blocked, zero with no grant.
  always_comb begin
    bus.SampI = '0;
    bus.SampQ = '0;
    if (gnt_a_s) begin
      bus.SampI = bus.ReqA_I;
      bus.SampQ = bus.ReqA_Q;
    end else if (gnt_b_s) begin
      bus.SampI = bus.ReqB_I;
      bus.SampQ = bus.ReqB_Q;
    end else begin
      bus.SampI = '0;
      bus.SampQ = '0;
    end
  end

  // Ownership and burst update; a full FIFO with a pending request freezes both.
  always_comb begin
    own_nxt_s  = own_r;
    bcnt_nxt_s = bcnt_r;
    if (xfer_s) begin
      own_nxt_s  = gnt_b_s ? OWN_B : OWN_A;
      bcnt_nxt_s = burst_next(bcnt_r, same_src_s);
    end else if (!bus.ReqA_Valid && !bus.ReqB_Valid) begin
      own_nxt_s  = IDLE;
      bcnt_nxt_s = 4'd0;
    end else begin
      own_nxt_s  = own_r;
      bcnt_nxt_s = bcnt_r;
    end
  end

  // State registers and debug stall counter.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      own_r       <= IDLE;
      bcnt_r      <= 4'd0;
      stall_cnt_r <= 16'd0;
    end else begin
      own_r  <= own_nxt_s;
      bcnt_r <= bcnt_nxt_s;
      if (stall_ev_s) begin
        stall_cnt_r <= sat_inc16(stall_cnt_r);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_samp_push_arbiter.sv
// Directed vector bench for samp_push_arbiter: one row per clock, expected grant hand-derived.
module tb_samp_push_arbiter;

  logic        Clk;
  logic        Reset;
  logic [15:0] StallCnt;

  samp_push_arbiter_if #(.SAMP_W(24)) bus ();

  samp_push_arbiter #(.SAMP_W(24), .BURST_MAX(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .bus      (bus),
    .StallCnt (StallCnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row fields {ValidA, ValidB, fifo_full, Reset, grant}; grant 0=none 1=A 2=B 3=unchecked.
  localparam logic [5:0] VEC [47] = '{
    6'b00_0_1_00,                                                   // reset, idle
    6'b10_0_0_01, 6'b10_0_0_01, 6'b10_0_0_01,                       // lone A stream
    6'b10_0_0_01, 6'b10_0_0_01, 6'b10_0_0_01,
    6'b00_0_0_00,
    6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01,         // fair share
    6'b11_0_0_10, 6'b11_0_0_10, 6'b11_0_0_10, 6'b11_0_0_10,
    6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01,
    6'b11_0_0_10, 6'b10_0_0_01, 6'b00_0_0_00,
    6'b10_0_0_01, 6'b10_1_0_01, 6'b10_1_0_01, 6'b10_1_0_01,         // backpressure
    6'b10_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_10,
    6'b10_0_0_01, 6'b10_0_0_01, 6'b01_0_0_10,                       // early switch
    6'b11_0_0_10, 6'b11_0_0_10, 6'b11_0_0_10, 6'b11_0_0_01,
    6'b11_0_0_01, 6'b11_0_1_11,                                     // reset mid-burst
    6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01, 6'b11_0_0_01,
    6'b11_0_0_10, 6'b10_0_0_01, 6'b00_0_0_00
  };

  // Requester obligation: a valid not yet accepted must hold with stable data.
  logic        pend_a = 1'b0;
  logic        pend_b = 1'b0;
  logic [23:0] held_ai, held_bi;
  always @(negedge Clk) begin
    if (pend_a) begin
      chk("hold_a_valid", {31'd0, bus.ReqA_Valid}, 32'd1);
      chk("hold_a_i", {8'd0, bus.ReqA_I}, {8'd0, held_ai});
    end
    if (pend_b) begin
      chk("hold_b_valid", {31'd0, bus.ReqB_Valid}, 32'd1);
      chk("hold_b_i", {8'd0, bus.ReqB_I}, {8'd0, held_bi});
    end
    pend_a  <= bus.ReqA_Valid && !bus.ReqA_Ready && !Reset;
    pend_b  <= bus.ReqB_Valid && !bus.ReqB_Ready && !Reset;
    held_ai <= bus.ReqA_I;
    held_bi <= bus.ReqB_I;
  end

  initial begin
    logic [5:0]  row;
    logic        va, vb, fl, rs;
    logic [1:0]  g;
    logic [23:0] na, nb, exp_i, exp_q;
    logic [15:0] stall_exp;
    logic        push_exp;

    na = 24'd1;
    nb = 24'd1;
    stall_exp = 16'd0;
    Reset = 1'b1;
    bus.ReqA_Valid = 1'b0;
    bus.ReqB_Valid = 1'b0;
    bus.ReqA_I = 24'd0;
    bus.ReqA_Q = 24'd0;
    bus.ReqB_I = 24'd0;
    bus.ReqB_Q = 24'd0;
    bus.fifo_full = 1'b0;

    for (int r = 0; r < 47; r++) begin
      row = VEC[r];
      va  = row[5];
      vb  = row[4];
      fl  = row[3];
      rs  = row[2];
      g   = row[1:0];
      Reset          = rs;
      bus.ReqA_Valid = va;
      bus.ReqB_Valid = vb;
      bus.ReqA_I     = na;
      bus.ReqA_Q     = 24'h5A0000 | na;
      bus.ReqB_I     = 24'h800000 | nb;
      bus.ReqB_Q     = 24'hC30000 | nb;
      bus.fifo_full  = fl;
      if (rs) stall_exp = 16'd0;

      push_exp = ((g == 2'd1) || (g == 2'd2)) && !fl;
      exp_i = (g == 2'd1) ? na : (g == 2'd2) ? (24'h800000 | nb) : 24'd0;
      exp_q = (g == 2'd1) ? (24'h5A0000 | na) : (g == 2'd2) ? (24'hC30000 | nb) : 24'd0;

      @(negedge Clk);
      if (g != 2'd3) begin
        chk($sformatf("r%0d push", r),  {31'd0, bus.PushIn},     {31'd0, push_exp});
        chk($sformatf("r%0d rdy_a", r), {31'd0, bus.ReqA_Ready}, {31'd0, (g == 2'd1) && !fl});
        chk($sformatf("r%0d rdy_b", r), {31'd0, bus.ReqB_Ready}, {31'd0, (g == 2'd2) && !fl});
        chk($sformatf("r%0d gsrc", r),  {31'd0, bus.GrantSrc},   {31'd0, (g == 2'd2) && !fl});
        chk($sformatf("r%0d samp_i", r), {8'd0, bus.SampI}, {8'd0, exp_i});
        chk($sformatf("r%0d samp_q", r), {8'd0, bus.SampQ}, {8'd0, exp_q});
      end
      chk($sformatf("r%0d one_rdy", r), {31'd0, bus.ReqA_Ready & bus.ReqB_Ready}, 32'd0);
      chk($sformatf("r%0d stall", r), {16'd0, StallCnt}, {16'd0, stall_exp});

      if (!rs) begin
        if (push_exp && (g == 2'd1)) na = na + 24'd1;
        if (push_exp && (g == 2'd2)) nb = nb + 24'd1;
        if ((va || vb) && fl && (stall_exp != 16'hFFFF)) stall_exp = stall_exp + 16'd1;
      end
      @(posedge Clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/samp_push_arbiter.md
# samp_push_arbiter

Two-source round-robin arbiter that shares the single push port of the I/Q sample FIFO between two sample producers (requesters A and B). It sits directly in front of the FIFO: it drives PushIn/SampI/SampQ, consumes the FIFO's fifo_full flag, and gives each producer a valid/ready handshake. Ownership is sticky, with a burst limit that bounds starvation. A saturating stall counter is kept for debug.

## Interface
- SAMP_W, default 24: width of each I and Q component.
- BURST_MAX, default 4: maximum consecutive grants to one source while the other is waiting. Legal range 1..15.
- Clk  in  1: clock.
- Reset  in  1: reset, asynchronous, active-high.
- ReqA_Valid  in  1: source A presents a sample.
- ReqA_I, ReqA_Q  in  SAMP_W each: source A sample.
- ReqA_Ready  out  1: source A sample accepted this cycle.
- ReqB_Valid, ReqB_I, ReqB_Q, ReqB_Ready: same as A, for source B.
- fifo_full  in  1: FIFO full flag.
- PushIn  out  1: FIFO write enable.
- SampI, SampQ  out  SAMP_W each: FIFO write data.
- GrantSrc  out  1: source of the current push (0 = A, 1 = B). Reads 0 when PushIn = 0.
- StallCnt  out  16: saturating count of cycles with a valid request blocked by fifo_full.

## Operation
- State register own ∈ {IDLE, OWN_A, OWN_B}. Burst counter bcnt is 4 bits, range 0..BURST_MAX, saturating.
- Grant selection (combinational):
  - IDLE: A if ReqA_Valid, else B if ReqB_Valid, else none. A wins the tie.
  - OWN_A: A if ReqA_Valid && (bcnt < BURST_MAX || !ReqB_Valid); else B if ReqB_Valid; else none.
  - OWN_B: mirror of OWN_A.
- Transfer: fires when grant != none and fifo_full = 0.
  - ReqX_Ready = granted(X) && !fifo_full.
  - PushIn = transfer.
  - SampI/SampQ = granted source's I/Q, or 0 when there is no grant.
  - GrantSrc = 1 only when the transfer is from B.
  - At most one Ready is high in any cycle.
- Next state on a transfer: own ← OWN_<granted>. If granted == previous owner, bcnt ← min(bcnt+1, BURST_MAX); otherwise bcnt ← 1.
- Next state with no transfer:
  - Both Valids low: own ← IDLE, bcnt ← 0.
  - Blocked by fifo_full: own and bcnt hold.
- The burst limit only forces a switch when the other source is valid. A lone source streams indefinitely, with bcnt held at BURST_MAX.
- StallCnt increments when (ReqA_Valid | ReqB_Valid) && fifo_full, and saturates at 16'hFFFF. It is cleared only by Reset.
- Requester obligation: once Valid is raised, Valid stays high and I/Q stay stable until Ready. The bench asserts this rule; the RTL does not check it.

## Timing
- Zero-latency handshake: Ready, PushIn and Samp are combinational from the Valids, fifo_full, own and bcnt. The FIFO writes on the same rising edge that completes the handshake.
- No combinational loop: fifo_full is decoded from registered FIFO pointers. The paths Valid→Ready and Valid→PushIn are permitted.
- Back-to-back transfers every cycle are supported. Throughput is 1 sample/cycle whenever the FIFO is not full.
- A push and a FIFO pull in the same cycle are legal. fifo_full is evaluated before that edge, so a full FIFO blocks the push even if it is pulled in the same cycle.
- Reset values while Reset is high:
  - own = IDLE, bcnt = 0, StallCnt = 0.
  - With Valids low: both Ready = 0, PushIn = 0, SampI/SampQ = 0, GrantSrc = 0.
- Reset asserted mid-burst: state clears immediately. A transfer coinciding with the Reset edge is not counted. After release, arbitration restarts from IDLE.

## Test plan
- Reset: assert Reset with both Valids low → Ready A/B = 0, PushIn = 0, SampI/SampQ = 0, GrantSrc = 0, StallCnt = 0.
- Lone stream: A valid for 6 cycles with samples I = 1..6, fifo_full = 0 → 6 consecutive pushes of I = 1..6, GrantSrc = 0, ReqB_Ready never high.
- Fair share (BURST_MAX = 4): A and B continuously valid → grant sequence A,A,A,A,B,B,B,B,A,A,A,A. ReqA_Ready and ReqB_Ready are never high together.
- Backpressure: A valid, fifo_full = 1 for 3 cycles then 0 → PushIn = 0 and ReqA_Ready = 0 for 3 cycles, StallCnt = 3, held sample pushed on the 4th cycle, own/bcnt unchanged across the stall.
- Early switch: owner A granted twice, then ReqA_Valid drops while B is valid → B granted the next cycle with bcnt = 1. If A returns, B keeps the grant up to 4 pushes.
- Reset mid-operation: after 2 A grants with both sources valid, pulse Reset for 1 cycle → after release the first push is from A, StallCnt = 0, and a full burst of 4 A grants precedes the first B grant.
